// File: rtl/n8255_prn_ctl.sv
// Centronics printer controller: buffers host bytes and drives an 8255 PPI bus master through the strobe handshake.
// Define N8255_PRN_BUSY_CHECK_EN to build the BUSY polling state and PRN_BUSY sampling.
module n8255_prn_ctl #(
    parameter int unsigned STB_BIT   = 0,
    parameter int unsigned BUSY_BIT  = 0,
    parameter int unsigned STB_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_empty,
    output logic       prn_busy,
    output logic       ppi_cs,
    output logic       ppi_wr,
    output logic [1:0] ppi_addr,
    output logic [7:0] ppi_wdata,
    input  logic [7:0] ppi_rdata,
    input  logic       ppi_wait_n
);

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] ADDR_PA  = 2'd0;
    localparam logic [1:0] ADDR_PB  = 2'd1;
    localparam logic [1:0] ADDR_CTL = 2'd3;

    // Port C bit set/reset control words: bit0 selects set (strobe released) or reset (strobe asserted).
    localparam logic [DATA_W-1:0] STB_HIGH  = {4'b0000, 3'(STB_BIT), 1'b1};
    localparam logic [DATA_W-1:0] STB_LOW   = {4'b0000, 3'(STB_BIT), 1'b0};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STB_WIDTH - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_POLL, S_DATA, S_STB_LO, S_HOLD, S_STB_HI, S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              push, pop, commit;
    logic              cs_nxt, wr_nxt;
    logic [1:0]        addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              unused_rdata;

`ifdef N8255_PRN_BUSY_CHECK_EN
    logic rd_busy;
    logic gap_poll;
    assign rd_busy = ppi_rdata[BUSY_BIT];
`endif

    assign unused_rdata = ^{ppi_rdata, ppi_rdata[BUSY_BIT]};

    // An access commits on the cycle the slave returns ready while chip select is up.
    assign commit    = ppi_cs && ppi_wait_n;
    assign push      = tx_valid && tx_ready;
    assign pop       = (state == S_DATA) && commit;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   if (commit) state_nxt = S_IDLE;
`ifdef N8255_PRN_BUSY_CHECK_EN
            S_IDLE:   if (count != '0) state_nxt = S_POLL;
            S_POLL:   if (commit) state_nxt = rd_busy ? S_GAP : S_DATA;
`else
            S_IDLE:   if (count != '0) state_nxt = S_DATA;
`endif
            S_DATA:   if (commit) state_nxt = S_STB_LO;
            S_STB_LO: if (commit) state_nxt = S_HOLD;
            S_HOLD:   if (hold_cnt == HOLD_LAST) state_nxt = S_STB_HI;
            S_STB_HI: if (commit) state_nxt = S_GAP;
`ifdef N8255_PRN_BUSY_CHECK_EN
            S_GAP:    state_nxt = gap_poll ? S_POLL : S_IDLE;
`else
            S_GAP:    state_nxt = S_IDLE;
`endif
            default:  state_nxt = S_INIT;
        endcase
    end

    // Next bus values; a commit always forces one chip-select-low cycle before the next access.
    always_comb begin
        cs_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = ppi_addr;
        wdata_nxt = ppi_wdata;
        if (!commit) begin
            case (state_nxt)
                S_INIT, S_STB_HI: begin
                    cs_nxt = 1'b1; wr_nxt = 1'b1; addr_nxt = ADDR_CTL; wdata_nxt = STB_HIGH;
                end
`ifdef N8255_PRN_BUSY_CHECK_EN
                S_POLL: begin
                    cs_nxt = 1'b1; wr_nxt = 1'b0; addr_nxt = ADDR_PB; wdata_nxt = '0;
                end
`endif
                S_DATA: begin
                    cs_nxt = 1'b1; wr_nxt = 1'b1; addr_nxt = ADDR_PA; wdata_nxt = mem[rptr];
                end
                S_STB_LO: begin
                    cs_nxt = 1'b1; wr_nxt = 1'b1; addr_nxt = ADDR_CTL; wdata_nxt = STB_LOW;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ppi_cs    <= 1'b0;
            ppi_wr    <= 1'b0;
            ppi_addr  <= '0;
            ppi_wdata <= '0;
            tx_ready  <= 1'b0;
            tx_empty  <= 1'b0;
            prn_busy  <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            hold_cnt  <= '0;
`ifdef N8255_PRN_BUSY_CHECK_EN
            gap_poll  <= 1'b0;
`endif
        end else begin
            ppi_cs    <= cs_nxt;
            ppi_wr    <= wr_nxt;
            ppi_addr  <= addr_nxt;
            ppi_wdata <= wdata_nxt;
            count     <= count_nxt;
            tx_ready  <= (count_nxt != CNT_W'(DEPTH));
            tx_empty  <= (state_nxt == S_IDLE) && (count_nxt == '0);
            hold_cnt  <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
`ifdef N8255_PRN_BUSY_CHECK_EN
            if ((state == S_POLL) && commit) begin
                prn_busy <= rd_busy;
                gap_poll <= rd_busy;
            end
`else
            prn_busy  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_n8255_prn_ctl.sv
// Bench for n8255_prn_ctl: PPI slave with random wait states, access recorder and a per-byte transaction model.
module tb_n8255_prn_ctl;

    localparam int unsigned STB_BIT   = 5;
    localparam int unsigned BUSY_BIT  = 0;
    localparam int unsigned STB_WIDTH = 8;
    localparam logic [7:0]  STB_H     = {4'b0000, 3'(STB_BIT), 1'b1};
    localparam logic [7:0]  STB_L     = {4'b0000, 3'(STB_BIT), 1'b0};
`ifdef N8255_PRN_BUSY_CHECK_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_empty, prn_busy;
    logic       ppi_cs, ppi_wr;
    logic [1:0] ppi_addr;
    logic [7:0] ppi_wdata;
    logic [7:0] ppi_rdata = 8'h00;
    logic       ppi_wait_n = 1'b0;

    int   checks = 0;
    int   failures = 0;
    int   proto_err = 0;
    int   cyc = 0;
    int   last_commit = -10;
    int   first_cyc = 0;
    int   age = 0;
    int   lat = 1;
    int   busy_left = 0;
    bit   stall = 1'b0;
    bit   rand_lat = 1'b0;
    bit   prev_cs = 1'b0;
    bit   prev_commit = 1'b0;
    acc_t cur, hold_acc;
    logic [7:0] rd;

    acc_t got_q[$];
    acc_t exp_q[$];
    int   got_first[$];
    int   got_commit[$];

    always #5 clk = ~clk;

    n8255_prn_ctl #(
        .STB_BIT   (STB_BIT),
        .BUSY_BIT  (BUSY_BIT),
        .STB_WIDTH (STB_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_empty   (tx_empty),
        .prn_busy   (prn_busy),
        .ppi_cs     (ppi_cs),
        .ppi_wr     (ppi_wr),
        .ppi_addr   (ppi_addr),
        .ppi_wdata  (ppi_wdata),
        .ppi_rdata  (ppi_rdata),
        .ppi_wait_n (ppi_wait_n)
    );

    // PPI slave and recorder: runs mid-cycle, decides wait state, logs each committed access.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (reset) begin
            ppi_wait_n  = 1'b0;
            prev_cs     = 1'b0;
            prev_commit = 1'b0;
        end else if (ppi_cs) begin
            cur = acc_t'{ppi_wr, ppi_addr, ppi_wdata};
            if (!prev_cs || prev_commit) begin
                if (cyc - last_commit < 2) proto_err++;
                first_cyc = cyc;
                age       = 0;
                lat       = rand_lat ? int'($urandom_range(0, 3)) : 1;
                hold_acc  = cur;
            end else if (cur !== hold_acc) begin
                proto_err++;
            end
            rd           = 8'($urandom);
            rd[BUSY_BIT] = (busy_left > 0);
            ppi_rdata    = rd;
            ppi_wait_n   = !stall && (age >= lat);
            age++;
            if (ppi_wait_n) begin
                got_q.push_back(acc_t'{ppi_wr, ppi_addr, ppi_wr ? ppi_wdata : 8'h00});
                got_first.push_back(first_cyc);
                got_commit.push_back(cyc);
                last_commit = cyc;
                if (!ppi_wr && busy_left > 0) busy_left--;
            end
            prev_commit = ppi_wait_n;
            prev_cs     = 1'b1;
        end else begin
            ppi_wait_n  = 1'b0;
            prev_commit = 1'b0;
            prev_cs     = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Model: every byte yields optional port-B reads, then port A data, strobe low, strobe high.
    task automatic add_byte(input logic [7:0] b, input int busy_polls);
        if (BUSY_EN)
            for (int k = 0; k <= busy_polls; k++) exp_q.push_back(acc_t'{1'b0, 2'd1, 8'h00});
        exp_q.push_back(acc_t'{1'b1, 2'd0, b});
        exp_q.push_back(acc_t'{1'b1, 2'd3, STB_L});
        exp_q.push_back(acc_t'{1'b1, 2'd3, STB_H});
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_acc%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            if (got_q[i] == acc_t'{1'b1, 2'd3, STB_L} && i + 1 < got_q.size())
                chk($sformatf("%s_hold%0d", tag, i),
                    32'(got_first[i+1] - got_commit[i] - 1), 32'(STB_WIDTH));
        end
        got_q.delete();
        exp_q.delete();
        got_first.delete();
        got_commit.delete();
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("push_timeout", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        @(negedge clk);
        while (!tx_empty && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(tx_empty), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_acc(input string tag, input int num);
        int n = 0;
        while (got_q.size() < num && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reach"}, 32'(got_q.size() >= num), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] bs[5];
        int         n;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({ppi_cs, ppi_wr, ppi_addr, ppi_wdata, prn_busy, tx_ready, tx_empty}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(tx_ready), 32'd1);
        wait_empty("init");
        exp_q.push_back(acc_t'{1'b1, 2'd3, STB_H});
        compare("init");

        // Single byte through the full strobe sequence.
        push(8'h41);
        wait_empty("one");
        add_byte(8'h41, 0);
        compare("one");

        // Fill the FIFO while the first data write is stalled, then a fifth push.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) bs[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) push(bs[i]);
        chk("full_not_ready", 32'(tx_ready), 32'd0);
        stall = 1'b0;
        push(bs[4]);
        wait_empty("five");
        for (int i = 0; i < 5; i++) add_byte(bs[i], 0);
        compare("five");

        // Long wait state on the data write.
        stall = 1'b1;
        b = 8'($urandom);
        push(b);
        n = 0;
        while (!(ppi_cs && ppi_wr && ppi_addr == 2'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ppi_cs && ppi_addr == 2'd0 && ppi_wdata == b) n++;
        end
        chk("stall_hold", 32'(n), 32'd20);
        stall = 1'b0;
        wait_empty("stall");
        add_byte(b, 0);
        compare("stall");

        // Random bytes, random wait states and random host spacing.
        rand_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            push(b);
            add_byte(b, 0);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_empty("rand");
        compare("rand");
        rand_lat = 1'b0;

`ifdef N8255_PRN_BUSY_CHECK_EN
        // Printer busy for three polls.
        busy_left = 3;
        b = 8'($urandom);
        push(b);
        wait_acc("busy", 2);
        chk("busy_flag_set", 32'(prn_busy), 32'd1);
        wait_empty("busy");
        add_byte(b, 3);
        compare("busy");
        chk("busy_flag_clr", 32'(prn_busy), 32'd0);
`endif

        // Reset while the strobe is held low with two bytes queued.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) bs[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) push(bs[i]);
        stall = 1'b0;
        wait_acc("hold", (BUSY_EN ? 1 : 0) + 2);
        if (BUSY_EN) exp_q.push_back(acc_t'{1'b0, 2'd1, 8'h00});
        exp_q.push_back(acc_t'{1'b1, 2'd0, bs[0]});
        exp_q.push_back(acc_t'{1'b1, 2'd3, STB_L});
        compare("pre_reset");
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", 32'({ppi_cs, tx_ready, tx_empty}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        wait_empty("abort");
        repeat (30) @(negedge clk);
        chk("abort_empty", 32'(tx_empty), 32'd1);
        exp_q.push_back(acc_t'{1'b1, 2'd3, STB_H});
        compare("abort");

        chk("protocol", 32'(proto_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
